// File: rtl/puf_eval_controller.sv
// ============================================================================
//  Module   : puf_eval_controller
//  Purpose  : Sequences a tristate ring-oscillator PUF datapath to produce one
//             response word. Each evaluation clears the frequency counters,
//             lets the oscillators settle, opens a fixed counting window and
//             compares the two counts. VOTES evaluations are majority-voted
//             into one response bit. An LFSR step then produces the next
//             challenge, until RESP_BITS bits are collected.
//  Ports    : clk           - system clock, rising edge
//             reset         - asynchronous, active-high
//             start         - begin a run (sampled only while idle)
//             challenge_in  - seed challenge, captured on the accepted start
//             count_a/b     - frequency counter values
//             puf_challenge - challenge presented to the PUF
//             cnt_clear     - counter clear for the datapath
//             puf_enable    - oscillator count-window enable
//             busy          - high from the accepted start until done
//             done          - one-cycle pulse; response valid from this cycle
//             response      - voted response; bit i comes from challenge i
//             tie_flag      - sticky: some evaluation saw count_a == count_b
//             sat_flag      - sticky: some sampled count was all-ones
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module puf_eval_controller #(
    parameter int          N         = 32,
    parameter int          CNT_W     = 16,
    parameter int          SETTLE    = 8,
    parameter int          WINDOW    = 1024,
    parameter int          VOTES     = 5,
    parameter int          RESP_BITS = 8,
    parameter logic [N-1:0] TAP_MASK = 32'h80200003
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N-1:0]         challenge_in,
    input  logic [CNT_W-1:0]     count_a,
    input  logic [CNT_W-1:0]     count_b,
    output logic [N-1:0]         puf_challenge,
    output logic                 cnt_clear,
    output logic                 puf_enable,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 tie_flag,
    output logic                 sat_flag
);

    localparam int c_ONES_W  = $clog2(VOTES + 1);
    localparam int c_BIT_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int c_TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_ONES_W-1:0] c_VOTE_LAST = c_ONES_W'(VOTES - 1);
    localparam logic [c_ONES_W-1:0] c_HALF      = c_ONES_W'(VOTES / 2);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(RESP_BITS - 1);
    localparam logic [c_TMR_W-1:0]  c_SETTLE_T  = c_TMR_W'(SETTLE);
    localparam logic [c_TMR_W-1:0]  c_WINDOW_T  = c_TMR_W'(WINDOW);
    localparam logic [c_TMR_W-1:0]  c_TMR_ONE   = c_TMR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETTLE = 3'd2,
        S_COUNT  = 3'd3,
        S_GUARD  = 3'd4,
        S_SAMPLE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                 r_state;
    logic [N-1:0]           r_chal;
    logic                   r_clr;
    logic                   r_en;
    logic                   r_busy;
    logic                   r_done;
    logic [RESP_BITS-1:0]   r_resp;
    logic                   r_tie;
    logic                   r_sat;
    logic [c_ONES_W-1:0]    r_vote;
    logic [c_ONES_W-1:0]    r_ones;
    logic [c_BIT_W-1:0]     r_bit;
    logic [c_TMR_W-1:0]     r_tmr;

    logic                   w_bit;
    logic                   w_tie;
    logic                   w_sat;
    logic [c_ONES_W-1:0]    w_ones_nxt;
    logic [N-1:0]           w_lfsr_nxt;

    // Sample-cycle decision; equal counts naturally give bit 0.
    assign w_bit      = (count_a > count_b);
    assign w_tie      = (count_a == count_b);
    assign w_sat      = (count_a == {CNT_W{1'b1}}) || (count_b == {CNT_W{1'b1}});
    // Vote tally including the sample being taken this cycle.
    assign w_ones_nxt = r_ones + c_ONES_W'(w_bit);
    assign w_lfsr_nxt = {r_chal[N-2:0], ^(r_chal & TAP_MASK)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_chal  <= '0;
            r_clr   <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_resp  <= '0;
            r_tie   <= 1'b0;
            r_sat   <= 1'b0;
            r_vote  <= '0;
            r_ones  <= '0;
            r_bit   <= '0;
            r_tmr   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_chal  <= challenge_in;
                        r_resp  <= '0;
                        r_tie   <= 1'b0;
                        r_sat   <= 1'b0;
                        r_vote  <= '0;
                        r_ones  <= '0;
                        r_bit   <= '0;
                        r_busy  <= 1'b1;
                        r_clr   <= 1'b1;
                        r_en    <= 1'b0;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    // Timer counts cycles spent in the next state, starting at 1.
                    r_tmr <= c_TMR_ONE;
                    if (SETTLE == 0) begin
                        r_clr   <= 1'b0;
                        r_en    <= 1'b1;
                        r_state <= S_COUNT;
                    end else begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_tmr == c_SETTLE_T) begin
                        r_tmr   <= c_TMR_ONE;
                        r_clr   <= 1'b0;
                        r_en    <= 1'b1;
                        r_state <= S_COUNT;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_ONE;
                    end
                end
                S_COUNT: begin
                    if (r_tmr == c_WINDOW_T) begin
                        r_en    <= 1'b0;
                        r_state <= S_GUARD;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_ONE;
                    end
                end
                S_GUARD: begin
                    // Counters resolve; counts are not trusted yet.
                    r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (w_tie) r_tie <= 1'b1;
                    if (w_sat) r_sat <= 1'b1;
                    if (r_vote != c_VOTE_LAST) begin
                        r_vote  <= r_vote + c_ONES_W'(1);
                        r_ones  <= w_ones_nxt;
                        r_clr   <= 1'b1;
                        r_state <= S_CLEAR;
                    end else begin
                        r_resp[r_bit] <= (w_ones_nxt > c_HALF);
                        r_vote        <= '0;
                        r_ones        <= '0;
                        if (r_bit != c_BIT_LAST) begin
                            r_bit   <= r_bit + c_BIT_W'(1);
                            r_chal  <= w_lfsr_nxt;
                            r_clr   <= 1'b1;
                            r_state <= S_CLEAR;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign puf_challenge = r_chal;
    assign cnt_clear     = r_clr;
    assign puf_enable    = r_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign response      = r_resp;
    assign tie_flag      = r_tie;
    assign sat_flag      = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_puf_eval_controller.sv
// ============================================================================
//  Module   : tb_puf_eval_controller
//  Purpose  : Self-checking bench for puf_eval_controller. A count driver
//             feeds per-evaluation counts from tables; the expected response,
//             flags, challenge sequence and latency come from a reference
//             model working from the voting/LFSR rules.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_puf_eval_controller;

    localparam int N         = 32;
    localparam int CNT_W     = 16;
    localparam int SETTLE    = 2;
    localparam int WINDOW    = 8;
    localparam int VOTES     = 3;
    localparam int RESP_BITS = 4;
    localparam int E         = SETTLE + WINDOW + 3;
    localparam int NEV       = VOTES * RESP_BITS;
    localparam int LAT       = NEV * E + 1;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic                 clk          = 1'b0;
    logic                 reset        = 1'b1;
    logic                 start        = 1'b0;
    logic [N-1:0]         challenge_in = '0;
    logic [CNT_W-1:0]     count_a      = '0;
    logic [CNT_W-1:0]     count_b      = '0;
    logic [N-1:0]         puf_challenge;
    logic                 cnt_clear;
    logic                 puf_enable;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic                 tie_flag;
    logic                 sat_flag;

    puf_eval_controller #(
        .N(N), .CNT_W(CNT_W), .SETTLE(SETTLE), .WINDOW(WINDOW),
        .VOTES(VOTES), .RESP_BITS(RESP_BITS), .TAP_MASK(TAPS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .challenge_in(challenge_in),
        .count_a(count_a), .count_b(count_b), .puf_challenge(puf_challenge),
        .cnt_clear(cnt_clear), .puf_enable(puf_enable), .busy(busy),
        .done(done), .response(response), .tie_flag(tie_flag), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] tab_a [NEV];
    logic [15:0] tab_b [NEV];
    logic [31:0] chal_seen [NEV];
    int          ev       = 0;
    int          done_cnt = 0;
    logic        en_q     = 1'b0;

    // Count driver / monitor: counts for evaluation ev are presented once
    // the window closes, and the challenge seen during each window is logged.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (!busy) begin
            ev = 0;
        end else begin
            if (puf_enable && !en_q && ev < NEV) chal_seen[ev] = puf_challenge;
            if (!puf_enable && en_q && ev < NEV) begin
                count_a = tab_a[ev];
                count_b = tab_b[ev];
                ev = ev + 1;
            end
        end
        en_q = puf_enable;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] c);
        int ones;
        ones = $countones(c & TAPS);
        return (c << 1) | 32'(ones % 2);
    endfunction

    function automatic logic [RESP_BITS-1:0] model_resp();
        logic [RESP_BITS-1:0] r;
        r = '0;
        for (int b = 0; b < RESP_BITS; b++) begin
            int wins;
            wins = 0;
            for (int v = 0; v < VOTES; v++)
                if (tab_a[b*VOTES+v] > tab_b[b*VOTES+v]) wins++;
            r[b] = (2 * wins > VOTES);
        end
        return r;
    endfunction

    function automatic logic model_tie();
        for (int i = 0; i < NEV; i++) if (tab_a[i] == tab_b[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_sat();
        for (int i = 0; i < NEV; i++)
            if (tab_a[i] == 16'hFFFF || tab_b[i] == 16'hFFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Fills count tables. mode: 0 all a>b, 1 votes W/L/W, 2 votes W/L/L, 3 random
    task automatic fill(input int mode);
        for (int i = 0; i < NEV; i++) begin
            case (mode)
                0: begin tab_a[i] = 16'd100; tab_b[i] = 16'd50; end
                1: begin
                    tab_a[i] = (i % VOTES == 1) ? 16'd40  : 16'd300;
                    tab_b[i] = (i % VOTES == 1) ? 16'd900 : 16'd120;
                end
                2: begin
                    tab_a[i] = (i % VOTES == 0) ? 16'd500 : 16'd10;
                    tab_b[i] = (i % VOTES == 0) ? 16'd20  : 16'd700;
                end
                default: begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    tab_a[i] = 16'($urandom);
                    tab_b[i] = 16'($urandom);
                    if (r == 0) tab_b[i] = tab_a[i];
                    if (r == 1) tab_a[i] = 16'hFFFF;
                end
            endcase
        end
    endtask

    // One complete run from start to done, checked against the model.
    task automatic run(input logic [31:0] seed, input bit pulse, input bit pattern, input string name);
        logic [31:0]          chal [RESP_BITS];
        logic [RESP_BITS-1:0] exp_resp;
        logic                 exp_tie, exp_sat;
        int                   d0, k;
        chal[0] = seed;
        for (int b = 1; b < RESP_BITS; b++) chal[b] = model_next(chal[b-1]);
        exp_resp = model_resp();
        exp_tie  = model_tie();
        exp_sat  = model_sat();
        d0       = done_cnt;

        challenge_in = seed;
        start = 1'b1;
        tick();
        start = 1'b0;
        challenge_in = ~seed;
        chk({name, " busy@start"}, 64'(busy), 64'd1);
        chk({name, " cleared@start"}, 64'({response, tie_flag, sat_flag}), 64'd0);
        chk({name, " chal@start"}, 64'(puf_challenge), 64'(seed));

        k = 1;
        while (!done && k < LAT + 20) begin
            if (pattern && k <= E) begin
                chk($sformatf("%s clr k=%0d", name, k), 64'(cnt_clear), 64'(k <= 1 + SETTLE));
                chk($sformatf("%s en k=%0d", name, k), 64'(puf_enable),
                    64'(k > 1 + SETTLE && k <= 1 + SETTLE + WINDOW));
            end
            if (pulse) start = (k == 50);
            tick();
            k++;
        end
        chk({name, " done"}, 64'(done), 64'd1);
        chk({name, " latency"}, 64'(k), 64'(LAT));
        chk({name, " busy@done"}, 64'(busy), 64'd0);
        chk({name, " response"}, 64'(response), 64'(exp_resp));
        chk({name, " tie"}, 64'(tie_flag), 64'(exp_tie));
        chk({name, " sat"}, 64'(sat_flag), 64'(exp_sat));
        chk({name, " evals"}, 64'(ev), 64'd0);
        chk({name, " last chal"}, 64'(puf_challenge), 64'(chal[RESP_BITS-1]));
        for (int i = 0; i < NEV; i++)
            chk($sformatf("%s chal ev%0d", name, i), 64'(chal_seen[i]), 64'(chal[i / VOTES]));

        // start during DONE must be ignored
        if (pulse) start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk({name, " one done"}, 64'(done_cnt), 64'(d0 + 1));
        chk({name, " idle after"}, 64'({busy, cnt_clear, puf_enable}), 64'd0);
        chk({name, " resp held"}, 64'(response), 64'(exp_resp));
    endtask

    initial begin
        int d0;
        // power-on reset
        reset = 1'b1;
        repeat (3) tick();
        chk("por outputs", 64'({puf_challenge, cnt_clear, puf_enable, busy, done,
                                response, tie_flag, sat_flag}), 64'd0);
        reset = 1'b0;
        tick();

        // reset in the middle of COUNT abandons the run
        fill(0);
        d0 = done_cnt;
        challenge_in = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid count en", 64'(puf_enable), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("async reset outputs", 64'({puf_challenge, cnt_clear, puf_enable, busy, done,
                                        response, tie_flag, sat_flag}), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (200) tick();
        chk("no done after reset", 64'(done_cnt), 64'(d0));
        chk("idle after reset", 64'({busy, cnt_clear, puf_enable}), 64'd0);

        // directed runs
        fill(0);
        run(32'h0000_0001, 1'b0, 1'b1, "allwin");
        chk("allwin const", 64'(response), 64'hF);

        fill(1);
        run(32'h1234_5678, 1'b0, 1'b0, "wlw");
        chk("wlw const", 64'(response), 64'hF);

        fill(2);
        run(32'h0F0F_0F0F, 1'b0, 1'b0, "wll");
        chk("wll const", 64'(response), 64'h0);

        fill(0);
        tab_a[4] = 16'd200;
        tab_b[4] = 16'd200;
        run(32'hA5A5_0001, 1'b0, 1'b0, "tie");
        chk("tie const", 64'({response, tie_flag, sat_flag}), 64'b1111_10);

        fill(0);
        tab_a[7] = 16'hFFFF;
        run(32'h8000_0000, 1'b1, 1'b0, "sat");
        chk("sat const", 64'({response, tie_flag, sat_flag}), 64'b1111_01);

        // randomized runs, with start pulsed mid-run and during DONE
        for (int r = 0; r < 4; r++) begin
            fill(3);
            run($urandom, 1'b1, (r == 0), $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
